// File: rtl/disp_pkg.sv
// Shared types and constants for the display view controller.
// The optional freeze feature is enabled with the DISP_VIEW_HOLD_EN macro.
package disp_pkg;

    typedef enum logic [0:0] {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } view_state_t;

    localparam int MAX_OFFSET = 4;
    localparam int NIB_W      = 4;
    localparam int SRC_IDX_W  = 3;
    localparam int OFF_W      = 3;
    localparam int WORD_W     = 32;

    // Window offset one nibble toward the MSB, clamped at MAX_OFFSET.
    function automatic logic [OFF_W-1:0] sat_inc(input logic [OFF_W-1:0] off);
        if (off == OFF_W'(MAX_OFFSET)) begin
            return off;
        end else begin
            return off + 3'd1;
        end
    endfunction

    // Window offset one nibble toward the LSB, clamped at zero.
    function automatic logic [OFF_W-1:0] sat_dec(input logic [OFF_W-1:0] off);
        if (off == 3'd0) begin
            return off;
        end else begin
            return off - 3'd1;
        end
    endfunction

endpackage

// File: rtl/disp_view_ctrl_if.sv
// Source bus into the view controller and the display-side outputs.
// master: the side that provides sources; slave: the view controller.
interface disp_view_ctrl_if #(parameter int NSRC = 4);
    import disp_pkg::*;

    logic [NSRC*WORD_W-1:0] src_data;
    logic [NSRC-1:0]        src_valid;
    logic [15:0]            view_word;
    logic [SRC_IDX_W-1:0]   sel_src;
    logic [OFF_W-1:0]       nib_offset;
    logic                   auto_mode;
    logic                   none_valid;

    modport master (
        output src_data, src_valid,
        input  view_word, sel_src, nib_offset, auto_mode, none_valid
    );

    modport slave (
        input  src_data, src_valid,
        output view_word, sel_src, nib_offset, auto_mode, none_valid
    );

endinterface

// File: rtl/btn_conditioner.sv
// Raw push-button conditioning: 2-flop synchroniser, debounce counter and a
// single-cycle pulse on each accepted press. After reset the pulse is held off
// until a released level has been seen, so a button held through reset is ignored.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic          armed_r;
    logic          pulse_r;
    logic [1:0]    prime_r;
    logic [CW-1:0] cnt_r;

    // Synchronise, debounce, arm after a confirmed release and emit the press pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            armed_r <= 1'b0;
            pulse_r <= 1'b0;
            prime_r <= 2'b00;
            cnt_r   <= {CW{1'b0}};
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            prime_r <= {prime_r[0], 1'b1};
            pulse_r <= 1'b0;
            if (sync2_r != level_r) begin
                if (cnt_r == CNT_LAST) begin
                    level_r <= sync2_r;
                    cnt_r   <= {CW{1'b0}};
                    if (sync2_r) begin
                        pulse_r <= armed_r;
                    end else begin
                        armed_r <= 1'b1;
                    end
                end else begin
                    cnt_r <= cnt_r + 1'b1;
                end
            end else if (!armed_r && !sync2_r && prime_r[1]) begin
                // Released level must be stable as long as a press would need to be.
                if (cnt_r == CNT_LAST) begin
                    armed_r <= 1'b1;
                    cnt_r   <= {CW{1'b0}};
                end else begin
                    cnt_r <= cnt_r + 1'b1;
                end
            end else begin
                cnt_r <= {CW{1'b0}};
            end
        end
    end

    assign pulse = pulse_r;

endmodule

// File: rtl/disp_view_ctrl.sv
// Seven-segment view controller: picks one of NSRC 32-bit debug sources,
// scrolls a 4-nibble window over it and optionally auto-cycles sources.
// Optional macro DISP_VIEW_HOLD_EN adds a 'hold' input that freezes view_word
// and pauses the auto timer.
module disp_view_ctrl #(
    parameter int NSRC            = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int AUTO_PERIOD     = 16
) (
    input  logic clk,
    input  logic rst,
`ifdef DISP_VIEW_HOLD_EN
    input  logic hold,
`endif
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_left,
    input  logic btn_right,
    disp_view_ctrl_if.slave bus
);
    import disp_pkg::*;

    localparam int TW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

    logic                 up_s, down_s, left_s, right_s;
    logic                 hold_s;
    logic                 src_chg_s;
    logic [7:0]           valid8_s;
    logic [SRC_IDX_W-1:0] next_s, prev_s, step_s;
    logic [WORD_W-1:0]    word_s, shifted_s;
    logic [15:0]          window_s;

    view_state_t          state_r;
    logic                 auto_r;
    logic [SRC_IDX_W-1:0] sel_r;
    logic [OFF_W-1:0]     nib_r;
    logic [TW-1:0]        timer_r;
    logic [15:0]          view_r;
    logic                 none_r;

    // First valid index scanning upward from cur+1 (wraps; may return cur).
    function automatic logic [SRC_IDX_W-1:0] next_valid(input logic [NSRC-1:0] v,
                                                        input logic [SRC_IDX_W-1:0] cur);
        logic [SRC_IDX_W-1:0] r;
        int idx;
        r = cur;
        for (int k = NSRC; k >= 1; k--) begin
            idx = (int'(cur) + k) % NSRC;
            if (v[idx]) begin
                r = SRC_IDX_W'(idx);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // First valid index scanning downward from cur-1 (wraps; may return cur).
    function automatic logic [SRC_IDX_W-1:0] prev_valid(input logic [NSRC-1:0] v,
                                                        input logic [SRC_IDX_W-1:0] cur);
        logic [SRC_IDX_W-1:0] r;
        int idx;
        r = cur;
        for (int k = NSRC; k >= 1; k--) begin
            idx = (int'(cur) - k + NSRC) % NSRC;
            if (v[idx]) begin
                r = SRC_IDX_W'(idx);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_up
        (.clk(clk), .rst(rst), .raw(btn_up),    .pulse(up_s));
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_down
        (.clk(clk), .rst(rst), .raw(btn_down),  .pulse(down_s));
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_left
        (.clk(clk), .rst(rst), .raw(btn_left),  .pulse(left_s));
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_right
        (.clk(clk), .rst(rst), .raw(btn_right), .pulse(right_s));

`ifdef DISP_VIEW_HOLD_EN
    assign hold_s = hold;
`else
    assign hold_s = 1'b0;
`endif

    // up and down together cancel; otherwise one of them selects the step direction.
    assign src_chg_s = up_s ^ down_s;
    assign valid8_s  = 8'(bus.src_valid);
    assign next_s    = next_valid(bus.src_valid, sel_r);
    assign prev_s    = prev_valid(bus.src_valid, sel_r);
    assign step_s    = up_s ? next_s : prev_s;

    // Select the current source word and cut the 4-nibble window out of it.
    always_comb begin
        word_s = {WORD_W{1'b0}};
        for (int i = 0; i < NSRC; i++) begin
            if (sel_r == SRC_IDX_W'(i)) begin
                word_s = bus.src_data[WORD_W*i +: WORD_W];
            end else begin
                word_s = word_s;
            end
        end
        shifted_s = word_s >> (NIB_W * int'(nib_r));
        window_s  = shifted_s[15:0];
    end

    // MANUAL/AUTO mode FSM with source selection, scroll offset and auto timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= MANUAL;
            auto_r  <= 1'b0;
            sel_r   <= {SRC_IDX_W{1'b0}};
            nib_r   <= {OFF_W{1'b0}};
            timer_r <= {TW{1'b0}};
        end else begin
            case (state_r)
                MANUAL: begin
                    if (src_chg_s) begin
                        sel_r <= step_s;
                        nib_r <= 3'd0;
                    end else if (left_s && right_s) begin
                        state_r <= AUTO;
                        auto_r  <= 1'b1;
                        timer_r <= {TW{1'b0}};
                    end else if (right_s) begin
                        nib_r <= sat_inc(nib_r);
                    end else if (left_s) begin
                        nib_r <= sat_dec(nib_r);
                    end else begin
                        nib_r <= nib_r;
                    end
                end
                AUTO: begin
                    if (src_chg_s) begin
                        sel_r   <= step_s;
                        nib_r   <= 3'd0;
                        state_r <= MANUAL;
                        auto_r  <= 1'b0;
                    end else if (left_s && right_s) begin
                        state_r <= MANUAL;
                        auto_r  <= 1'b0;
                    end else begin
                        if (right_s) begin
                            nib_r <= sat_inc(nib_r);
                        end else if (left_s) begin
                            nib_r <= sat_dec(nib_r);
                        end else begin
                            nib_r <= nib_r;
                        end
                        // Terminal count overrides a same-cycle scroll: new source starts at offset 0.
                        if (hold_s) begin
                            timer_r <= timer_r;
                        end else if (timer_r == TW'(AUTO_PERIOD - 1)) begin
                            timer_r <= {TW{1'b0}};
                            sel_r   <= next_s;
                            nib_r   <= 3'd0;
                        end else begin
                            timer_r <= timer_r + 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= MANUAL;
                    auto_r  <= 1'b0;
                end
            endcase
            // A source that disappears is replaced in either mode; this wins over buttons.
            if ((bus.src_valid != {NSRC{1'b0}}) && !valid8_s[sel_r]) begin
                sel_r <= next_s;
                nib_r <= 3'd0;
            end
        end
    end

    // Registered display word and empty-source flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            view_r <= 16'h0000;
            none_r <= 1'b0;
        end else begin
            none_r <= (bus.src_valid == {NSRC{1'b0}});
            if (hold_s) begin
                view_r <= view_r;
            end else if (bus.src_valid == {NSRC{1'b0}}) begin
                view_r <= 16'h0000;
            end else begin
                view_r <= window_s;
            end
        end
    end

    assign bus.view_word  = view_r;
    assign bus.sel_src    = sel_r;
    assign bus.nib_offset = nib_r;
    assign bus.auto_mode  = auto_r;
    assign bus.none_valid = none_r;

endmodule

// File: tb/tb_disp_view_ctrl.sv
// Self-checking bench for disp_view_ctrl: table of button presses with a
// scoreboard of expected display state, plus hand-written latency, AUTO and
// reset sequences. The hold sequence is built only with DISP_VIEW_HOLD_EN.
module tb_disp_view_ctrl;

    localparam logic [3:0] B_UP    = 4'b0001;
    localparam logic [3:0] B_DOWN  = 4'b0010;
    localparam logic [3:0] B_LEFT  = 4'b0100;
    localparam logic [3:0] B_RIGHT = 4'b1000;

    localparam logic [31:0] SRC0 = 32'h89ABCDEF;
    localparam logic [31:0] SRC1 = 32'h01234567;
    localparam logic [31:0] SRC2 = 32'hFEDCBA98;
    localparam logic [31:0] SRC3 = 32'h13579BDF;

    typedef struct {
        logic [2:0]  sel;
        logic [2:0]  off;
        logic        auto_m;
        logic        none;
        logic [15:0] view;
    } exp_t;

    typedef struct {
        logic [3:0] btn;
        logic [3:0] valid;
        exp_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic btn_up, btn_down, btn_left, btn_right;
`ifdef DISP_VIEW_HOLD_EN
    logic hold;
`endif

    int tests = 0;
    int fails = 0;

    vec_t vecs[24];
    exp_t sb_q[$];

    always #5 clk = ~clk;

    disp_view_ctrl_if #(.NSRC(4)) bus();

    disp_view_ctrl #(.NSRC(4), .DEBOUNCE_CYCLES(4), .AUTO_PERIOD(16)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef DISP_VIEW_HOLD_EN
        .hold      (hold),
`endif
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .bus       (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input exp_t e);
        chk({tag, ".sel"},  32'(bus.sel_src),    32'(e.sel));
        chk({tag, ".off"},  32'(bus.nib_offset), 32'(e.off));
        chk({tag, ".auto"}, 32'(bus.auto_mode),  32'(e.auto_m));
        chk({tag, ".none"}, 32'(bus.none_valid), 32'(e.none));
        chk({tag, ".view"}, 32'(bus.view_word),  32'(e.view));
    endtask

    task automatic set_btn(input logic [3:0] m);
        btn_up    = m[0];
        btn_down  = m[1];
        btn_left  = m[2];
        btn_right = m[3];
    endtask

    // Press long enough to be accepted, then release long enough to re-arm.
    task automatic press(input logic [3:0] m);
        @(negedge clk);
        set_btn(m);
        repeat (8) @(negedge clk);
        set_btn(4'b0000);
        repeat (10) @(negedge clk);
    endtask

    function automatic vec_t mk(input logic [3:0] b, input logic [3:0] v,
                                input logic [2:0] s, input logic [2:0] o,
                                input logic a, input logic n, input logic [15:0] w);
        vec_t r;
        r.btn = b;
        r.valid = v;
        r.exp.sel = s;
        r.exp.off = o;
        r.exp.auto_m = a;
        r.exp.none = n;
        r.exp.view = w;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        exp_t e;

        // Scroll saturation, up+down cancel, source skipping, empty set, validity drop.
        vecs[0]  = mk(B_RIGHT,          4'b1111, 3'd0, 3'd2, 1'b0, 1'b0, 16'hABCD);
        vecs[1]  = mk(B_RIGHT,          4'b1111, 3'd0, 3'd3, 1'b0, 1'b0, 16'h9ABC);
        vecs[2]  = mk(B_RIGHT,          4'b1111, 3'd0, 3'd4, 1'b0, 1'b0, 16'h89AB);
        vecs[3]  = mk(B_RIGHT,          4'b1111, 3'd0, 3'd4, 1'b0, 1'b0, 16'h89AB);
        vecs[4]  = mk(B_RIGHT,          4'b1111, 3'd0, 3'd4, 1'b0, 1'b0, 16'h89AB);
        vecs[5]  = mk(B_LEFT,           4'b1111, 3'd0, 3'd3, 1'b0, 1'b0, 16'h9ABC);
        vecs[6]  = mk(B_LEFT,           4'b1111, 3'd0, 3'd2, 1'b0, 1'b0, 16'hABCD);
        vecs[7]  = mk(B_LEFT,           4'b1111, 3'd0, 3'd1, 1'b0, 1'b0, 16'hBCDE);
        vecs[8]  = mk(B_LEFT,           4'b1111, 3'd0, 3'd0, 1'b0, 1'b0, 16'hCDEF);
        vecs[9]  = mk(B_LEFT,           4'b1111, 3'd0, 3'd0, 1'b0, 1'b0, 16'hCDEF);
        vecs[10] = mk(B_RIGHT,          4'b1111, 3'd0, 3'd1, 1'b0, 1'b0, 16'hBCDE);
        vecs[11] = mk(B_UP | B_DOWN,    4'b1111, 3'd0, 3'd1, 1'b0, 1'b0, 16'hBCDE);
        vecs[12] = mk(B_UP,             4'b1011, 3'd1, 3'd0, 1'b0, 1'b0, 16'h4567);
        vecs[13] = mk(B_UP,             4'b1011, 3'd3, 3'd0, 1'b0, 1'b0, 16'h9BDF);
        vecs[14] = mk(B_UP,             4'b1011, 3'd0, 3'd0, 1'b0, 1'b0, 16'hCDEF);
        vecs[15] = mk(B_DOWN,           4'b1011, 3'd3, 3'd0, 1'b0, 1'b0, 16'h9BDF);
        vecs[16] = mk(B_RIGHT,          4'b1011, 3'd3, 3'd1, 1'b0, 1'b0, 16'h79BD);
        vecs[17] = mk(B_UP | B_RIGHT,   4'b1011, 3'd0, 3'd0, 1'b0, 1'b0, 16'hCDEF);
        vecs[18] = mk(4'b0000,          4'b0000, 3'd0, 3'd0, 1'b0, 1'b1, 16'h0000);
        vecs[19] = mk(4'b0000,          4'b1111, 3'd0, 3'd0, 1'b0, 1'b0, 16'hCDEF);
        vecs[20] = mk(B_UP,             4'b1111, 3'd1, 3'd0, 1'b0, 1'b0, 16'h4567);
        vecs[21] = mk(4'b0000,          4'b1101, 3'd2, 3'd0, 1'b0, 1'b0, 16'hBA98);
        vecs[22] = mk(B_RIGHT,          4'b1111, 3'd2, 3'd1, 1'b0, 1'b0, 16'hCBA9);
        vecs[23] = mk(B_DOWN,           4'b1111, 3'd1, 3'd0, 1'b0, 1'b0, 16'h4567);

        // Reset with every button held.
        rst = 1'b1;
        set_btn(4'b1111);
`ifdef DISP_VIEW_HOLD_EN
        hold = 1'b0;
`endif
        bus.src_data  = {SRC3, SRC2, SRC1, SRC0};
        bus.src_valid = 4'b1111;
        repeat (2) @(negedge clk);
        e = '{3'd0, 3'd0, 1'b0, 1'b0, 16'h0000};
        chk_state("reset", e);

        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("held_after_reset.sel",  32'(bus.sel_src),    32'd0);
        chk("held_after_reset.off",  32'(bus.nib_offset), 32'd0);
        chk("held_after_reset.auto", 32'(bus.auto_mode),  32'd0);
        set_btn(4'b0000);
        repeat (12) @(negedge clk);
        e = '{3'd0, 3'd0, 1'b0, 1'b0, 16'hCDEF};
        chk_state("released", e);

        // Glitch of 3 cycles is rejected.
        set_btn(B_RIGHT);
        repeat (3) @(negedge clk);
        set_btn(4'b0000);
        repeat (8) @(negedge clk);
        chk("glitch.off", 32'(bus.nib_offset), 32'd0);

        // Accepted press: 2 sync + 4 debounce edges, then offset, then view.
        set_btn(B_RIGHT);
        repeat (6) @(negedge clk);
        chk("latency.off_early", 32'(bus.nib_offset), 32'd0);
        @(negedge clk);
        chk("latency.off",        32'(bus.nib_offset), 32'd1);
        chk("latency.view_early", 32'(bus.view_word),  32'h0000CDEF);
        @(negedge clk);
        chk("latency.view",       32'(bus.view_word),  32'h0000BCDE);
        repeat (10) @(negedge clk);
        chk("latency.no_repeat",  32'(bus.nib_offset), 32'd1);
        set_btn(4'b0000);
        repeat (10) @(negedge clk);

        // Table of presses, expectations queued as each is driven.
        for (int i = 0; i < 24; i++) begin
            bus.src_valid = vecs[i].valid;
            sb_q.push_back(vecs[i].exp);
            if (vecs[i].btn != 4'b0000) begin
                press(vecs[i].btn);
            end else begin
                repeat (4) @(negedge clk);
            end
            e = sb_q.pop_front();
            chk_state($sformatf("vec%0d", i), e);
        end

        // AUTO mode: enter from source 0, advance every 16 cycles, exit with down.
        press(B_DOWN);
        chk("auto_pre.sel", 32'(bus.sel_src), 32'd0);
        @(negedge clk);
        set_btn(B_LEFT | B_RIGHT);
        for (int c = 0; c < 30 && !bus.auto_mode; c++) begin
            @(negedge clk);
        end
        chk("auto.enter", 32'(bus.auto_mode), 32'd1);
        set_btn(4'b0000);
        for (int k = 1; k <= 4; k++) begin
            repeat (15) @(negedge clk);
            chk($sformatf("auto.hold%0d", k), 32'(bus.sel_src), 32'((k - 1) % 4));
            @(negedge clk);
            chk($sformatf("auto.step%0d", k), 32'(bus.sel_src), 32'(k % 4));
        end
        chk("auto.still", 32'(bus.auto_mode), 32'd1);
        press(B_DOWN);
        chk("auto_exit.sel",  32'(bus.sel_src),   32'd3);
        chk("auto_exit.auto", 32'(bus.auto_mode), 32'd0);
        repeat (20) @(negedge clk);
        chk("manual_stays.sel", 32'(bus.sel_src), 32'd3);

`ifdef DISP_VIEW_HOLD_EN
        // Hold freezes view_word; release shows the new value next cycle.
        press(B_UP);
        bus.src_data[31:0] = 32'h00000001;
        repeat (3) @(negedge clk);
        chk("hold.before", 32'(bus.view_word), 32'h00000001);
        hold = 1'b1;
        bus.src_data[31:0] = 32'h00000002;
        repeat (3) @(negedge clk);
        chk("hold.frozen", 32'(bus.view_word), 32'h00000001);
        hold = 1'b0;
        @(negedge clk);
        chk("hold.release", 32'(bus.view_word), 32'h00000002);
`endif

        // Reset mid-operation with a button held through it.
        press(B_RIGHT);
        chk("mid.off_before", 32'(bus.nib_offset), 32'd1);
        rst = 1'b1;
        set_btn(B_RIGHT);
        repeat (2) @(negedge clk);
        e = '{3'd0, 3'd0, 1'b0, 1'b0, 16'h0000};
        chk_state("mid_reset", e);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("mid.held_off", 32'(bus.nib_offset), 32'd0);
        set_btn(4'b0000);
        repeat (12) @(negedge clk);
        press(B_RIGHT);
        chk("mid.rearmed_off", 32'(bus.nib_offset), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
